sram_responder: RTL and testbench

- Responder (slave) end of the single-cycle SRAM-like data interface that the CPU core drives with en/wen/addr/wdata and samples rdata from.
- Provides a word-addressed on-chip data RAM with byte write enables and a one-cycle registered read.
- Also provides a small memory-mapped config-register window: LED, NUM, free-running TIMER, COMPARE, and a timer interrupt output wired to one ext_int line of the CPU.
- Used as the data-side memory in non-AXI system builds and in stage/unit benches.

---
 rtl/sram_responder_if.sv | 10 +
 rtl/sram_responder.sv | 68 ++++++
 tb/tb_sram_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// sram_responder_if: single-cycle SRAM-like data bus between the CPU core and a responder.
interface sram_responder_if;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   modport master (output en, wen, addr, wdata, input rdata);
   modport slave  (input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/sram_responder.sv
// sram_responder: word-addressed data RAM with byte enables plus LED/NUM/TIMER/COMPARE config window.
module sram_responder #(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [15:0] CONF_HI    = 16'hbfaf
) (
   input  logic                 clk,
   input  logic                 resetn,
   sram_responder_if.slave      sram,
   output logic [15:0]          led,
   output logic [31:0]          num_data,
   output logic                 timer_int
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   logic [31:0] mem [DEPTH];
   logic [31:0] timer, compare, timer_inc, bmask, rd_word;
   logic [31:0] led_new, num_new, timer_new, compare_new;
   logic [ADDR_WIDTH-1:0] idx;
   logic [15:0] off;
   logic conf_sel, wr, sel_led, sel_num, sel_tmr, sel_cmp;
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [31:0] m);
      return (old & ~m) | (nw & m);
   endfunction
   always_comb begin
      conf_sel    = sram.addr[31:16] == CONF_HI;
      idx         = sram.addr[ADDR_WIDTH+1:2];
      off         = {sram.addr[15:2], 2'b00};
      wr          = sram.en && (sram.wen != 4'b0000);
      bmask       = {{8{sram.wen[3]}}, {8{sram.wen[2]}}, {8{sram.wen[1]}}, {8{sram.wen[0]}}};
      sel_led     = conf_sel && off == 16'hf000;
      sel_num     = conf_sel && off == 16'hf010;
      sel_tmr     = conf_sel && off == 16'he000;
      sel_cmp     = conf_sel && off == 16'he004;
      timer_inc   = timer + 32'd1;
      led_new     = merge({16'h0000, led}, sram.wdata, bmask);
      num_new     = merge(num_data, sram.wdata, bmask);
      timer_new   = (wr && sel_tmr) ? merge(timer_inc, sram.wdata, bmask) : timer_inc;
      compare_new = merge(compare, sram.wdata, bmask);
      rd_word     = !conf_sel ? mem[idx] :
                    sel_led   ? {16'h0000, led} :
                    sel_num   ? num_data :
                    sel_tmr   ? timer :
                    sel_cmp   ? compare : 32'h0;
   end
   // RAM is never reset; writes in a reset cycle are suppressed.
   always_ff @(posedge clk) begin
      if (resetn && wr && !conf_sel)
         for (int i = 0; i < 4; i++)
            if (sram.wen[i]) mem[idx][8*i +: 8] <= sram.wdata[8*i +: 8];
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sram.rdata <= 32'h0;
         led        <= 16'h0;
         num_data   <= 32'h0;
         timer      <= 32'h0;
         compare    <= 32'h0;
         timer_int  <= 1'b0;
      end else begin
         if (sram.en) sram.rdata <= rd_word;
         if (wr && sel_led) led <= led_new[15:0];
         if (wr && sel_num) num_data <= num_new;
         if (wr && sel_cmp) compare <= compare_new;
         timer     <= timer_new;
         // a COMPARE write clears the interrupt even if a match happens in the same cycle
         timer_int <= (wr && sel_cmp) ? 1'b0 : (compare != 32'h0 && timer == compare) ? 1'b1 : timer_int;
      end
   end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: table-driven checks of RAM/config accesses plus timer and interrupt sequences.
module tb_sram_responder;
   logic clk = 1'b0;
   logic resetn;
   logic [15:0] led;
   logic [31:0] num_data;
   logic timer_int;
   int n_cmp = 0;
   int n_bad = 0;
   sram_responder_if bus ();
   sram_responder #(.ADDR_WIDTH(12), .CONF_HI(16'hbfaf)) dut (
      .clk(clk), .resetn(resetn), .sram(bus.slave),
      .led(led), .num_data(num_data), .timer_int(timer_int)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic        rn;
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] rdata;
      logic [15:0] led;
      logic [31:0] num;
   } vec_t;
   vec_t v [27];
   task automatic step(input logic rn, input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
      resetn    = rn;
      bus.en    = en;
      bus.wen   = wen;
      bus.addr  = addr;
      bus.wdata = wdata;
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, got, exp);
      end
   endtask
   initial begin
      v[0]  = '{0, 0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1, 32'h0000_0000, 16'h0000, 32'h0000_0000};
      v[1]  = '{1, 1, 4'hf, 32'h0000_0010, 32'h0000_0000, 0, 32'h0000_0000, 16'h0000, 32'h0000_0000};
      v[2]  = '{1, 1, 4'hf, 32'h0000_0000, 32'h1111_1111, 0, 32'h0000_0000, 16'h0000, 32'h0000_0000};
      v[3]  = '{0, 1, 4'h0, 32'h0000_0010, 32'h0000_0000, 1, 32'h0000_0000, 16'h0000, 32'h0000_0000};
      v[4]  = '{1, 1, 4'h0, 32'h0000_0010, 32'h0000_0000, 1, 32'h0000_0000, 16'h0000, 32'h0000_0000};
      v[5]  = '{1, 1, 4'hf, 32'h0000_0100, 32'hdead_beef, 0, 32'h0000_0000, 16'h0000, 32'h0000_0000};
      v[6]  = '{1, 1, 4'h1, 32'h0000_0100, 32'h0000_00aa, 1, 32'hdead_beef, 16'h0000, 32'h0000_0000};
      v[7]  = '{1, 1, 4'h0, 32'h0000_0100, 32'h0000_0000, 1, 32'hdead_beaa, 16'h0000, 32'h0000_0000};
      v[8]  = '{1, 1, 4'hf, 32'h0000_4000, 32'h1234_5678, 1, 32'h1111_1111, 16'h0000, 32'h0000_0000};
      v[9]  = '{1, 1, 4'h0, 32'h0000_0000, 32'h0000_0000, 1, 32'h1234_5678, 16'h0000, 32'h0000_0000};
      v[10] = '{1, 0, 4'hf, 32'h0000_0100, 32'hffff_ffff, 1, 32'h1234_5678, 16'h0000, 32'h0000_0000};
      v[11] = '{1, 1, 4'h0, 32'h0000_0100, 32'h0000_0000, 1, 32'hdead_beaa, 16'h0000, 32'h0000_0000};
      v[12] = '{1, 1, 4'hf, 32'hbfaf_f000, 32'h0000_a5a5, 1, 32'h0000_0000, 16'ha5a5, 32'h0000_0000};
      v[13] = '{1, 1, 4'hf, 32'hbfaf_f010, 32'hcafe_f00d, 1, 32'h0000_0000, 16'ha5a5, 32'hcafe_f00d};
      v[14] = '{1, 1, 4'h0, 32'hbfaf_f000, 32'h0000_0000, 1, 32'h0000_a5a5, 16'ha5a5, 32'hcafe_f00d};
      v[15] = '{1, 1, 4'h0, 32'hbfaf_f020, 32'h0000_0000, 1, 32'h0000_0000, 16'ha5a5, 32'hcafe_f00d};
      v[16] = '{1, 1, 4'h2, 32'hbfaf_f000, 32'h1234_5678, 1, 32'h0000_a5a5, 16'h56a5, 32'hcafe_f00d};
      v[17] = '{1, 1, 4'hc, 32'hbfaf_f000, 32'hffff_ffff, 1, 32'h0000_56a5, 16'h56a5, 32'hcafe_f00d};
      v[18] = '{1, 1, 4'h0, 32'hbfaf_f010, 32'h0000_0000, 1, 32'hcafe_f00d, 16'h56a5, 32'hcafe_f00d};
      v[19] = '{1, 1, 4'hf, 32'hbfaf_f020, 32'h0000_1234, 1, 32'h0000_0000, 16'h56a5, 32'hcafe_f00d};
      v[20] = '{1, 1, 4'h0, 32'hbfaf_f020, 32'h0000_0000, 1, 32'h0000_0000, 16'h56a5, 32'hcafe_f00d};
      v[21] = '{1, 1, 4'hf, 32'h0000_0208, 32'h0000_0055, 0, 32'h0000_0000, 16'h56a5, 32'hcafe_f00d};
      v[22] = '{1, 1, 4'hf, 32'h0000_0200, 32'h0000_0001, 0, 32'h0000_0000, 16'h56a5, 32'hcafe_f00d};
      v[23] = '{0, 1, 4'hf, 32'h0000_0208, 32'h0000_0003, 1, 32'h0000_0000, 16'h0000, 32'h0000_0000};
      v[24] = '{1, 1, 4'h0, 32'h0000_0200, 32'h0000_0000, 1, 32'h0000_0001, 16'h0000, 32'h0000_0000};
      v[25] = '{1, 1, 4'h0, 32'h0000_0208, 32'h0000_0000, 1, 32'h0000_0055, 16'h0000, 32'h0000_0000};
      v[26] = '{1, 1, 4'h0, 32'h8000_0100, 32'h0000_0000, 1, 32'hdead_beaa, 16'h0000, 32'h0000_0000};
      for (int i = 0; i < 27; i++) begin
         step(v[i].rn, v[i].en, v[i].wen, v[i].addr, v[i].wdata);
         if (v[i].chk) check($sformatf("v%0d rdata", i), bus.rdata, v[i].rdata);
         check($sformatf("v%0d led", i), {16'h0, led}, {16'h0, v[i].led});
         check($sformatf("v%0d num", i), num_data, v[i].num);
         check($sformatf("v%0d int", i), {31'h0, timer_int}, 32'h0);
      end
      step(1, 1, 4'hf, 32'hbfaf_e000, 32'hffff_fffe);
      step(1, 1, 4'hf, 32'hbfaf_e004, 32'h0000_0003);
      check("cmp set int", {31'h0, timer_int}, 32'h0);
      step(1, 1, 4'h0, 32'hbfaf_e000, 32'h0);
      check("timer max", bus.rdata, 32'hffff_ffff);
      step(1, 1, 4'h0, 32'hbfaf_e000, 32'h0);
      check("timer wrap", bus.rdata, 32'h0000_0000);
      step(1, 0, 4'h0, 32'h0, 32'h0);
      check("int pre2", {31'h0, timer_int}, 32'h0);
      step(1, 0, 4'h0, 32'h0, 32'h0);
      check("int pre3", {31'h0, timer_int}, 32'h0);
      step(1, 0, 4'h0, 32'h0, 32'h0);
      check("int rise", {31'h0, timer_int}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 4'h0, 32'hbfaf_e004, 32'h0);
         check($sformatf("int hold%0d", i), {31'h0, timer_int}, 32'h1);
         check($sformatf("cmp read%0d", i), bus.rdata, 32'h0000_0003);
      end
      step(1, 1, 4'hf, 32'hbfaf_e004, 32'h0000_0100);
      check("int clear", {31'h0, timer_int}, 32'h0);
      step(1, 1, 4'hf, 32'hbfaf_e000, 32'h0000_0050);
      step(1, 1, 4'hf, 32'hbfaf_e004, 32'h0000_0051);
      check("int after cmp", {31'h0, timer_int}, 32'h0);
      step(1, 1, 4'hf, 32'hbfaf_e004, 32'h0000_0051);
      check("clear wins", {31'h0, timer_int}, 32'h0);
      step(1, 0, 4'h0, 32'h0, 32'h0);
      check("clear wins hold", {31'h0, timer_int}, 32'h0);
      step(1, 1, 4'hf, 32'hbfaf_e000, 32'h0000_01ff);
      step(1, 1, 4'h1, 32'hbfaf_e000, 32'hffff_ff10);
      step(1, 1, 4'h0, 32'hbfaf_e000, 32'h0);
      check("timer partial", bus.rdata, 32'h0000_0210);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
